// File: rtl/cr16_datapath_pipe_if.sv
// Issue/result bus of the CR16 pipelined datapath.
// The control FSM drives the master side; the datapath sits on the slave side.
interface cr16_datapath_pipe_if #(
   parameter int DATA_WIDTH = 16,
   parameter int SEL_WIDTH  = 4
);
   logic                  I_ENABLE;
   logic                  I_VALID;
   logic [3:0]            I_OPCODE;
   logic [SEL_WIDTH-1:0]  I_READ_PORT_A_SEL;
   logic [SEL_WIDTH-1:0]  I_READ_PORT_B_SEL;
   logic [SEL_WIDTH-1:0]  I_WRITE_SEL;
   logic                  I_WRITE_EN;
   logic [DATA_WIDTH-1:0] I_IMMEDIATE;
   logic                  I_IMM_SEL;
   logic [DATA_WIDTH-1:0] O_WRITE_PORT;
   logic                  O_RESULT_VALID;
   logic [4:0]            O_FLAGS;

   modport master (
      output I_ENABLE, I_VALID, I_OPCODE, I_READ_PORT_A_SEL, I_READ_PORT_B_SEL,
             I_WRITE_SEL, I_WRITE_EN, I_IMMEDIATE, I_IMM_SEL,
      input  O_WRITE_PORT, O_RESULT_VALID, O_FLAGS
   );

   modport slave (
      input  I_ENABLE, I_VALID, I_OPCODE, I_READ_PORT_A_SEL, I_READ_PORT_B_SEL,
             I_WRITE_SEL, I_WRITE_EN, I_IMMEDIATE, I_IMM_SEL,
      output O_WRITE_PORT, O_RESULT_VALID, O_FLAGS
   );
endinterface

// File: rtl/cr16_datapath_pipe.sv
// CR16 datapath as a 2-stage pipeline: EX (operand read + ALU) -> WB (register write),
// with WB->EX bypass so dependent ops issue back-to-back. PSR flags are {C,L,F,Z,N}.
module cr16_datapath_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 16,
   parameter int SEL_WIDTH  = 4
) (
   input  logic               I_CLK,
   input  logic               I_NRESET,
   cr16_datapath_pipe_if.slave bus
);
   localparam int SHW = $clog2(DATA_WIDTH);

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
      OP_XOR  = 4'h4, OP_MOV = 4'h5, OP_CMP = 4'h6, OP_LSH = 4'h7,
      OP_RSH  = 4'h8, OP_ADDC = 4'h9, OP_NOT = 4'hA
   } op_e;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] wr_q, wr_d;
   logic [4:0]            flags_q, flags_d;
   logic                  valid_q;
   logic                  wb_we_q, wb_we_d;
   logic [SEL_WIDTH-1:0]  wb_sel_q;

   logic [DATA_WIDTH-1:0] a_val, b_reg, b_val;
   logic [DATA_WIDTH:0]   sum, diff;
   logic [SHW-1:0]        amt;
   logic                  writes, ovf;
   op_e                   op;

   // Operand read: out-of-range selects read 0; a pending WB to the same register wins.
   always_comb begin
      a_val = '0;
      b_reg = '0;
      if (int'(bus.I_READ_PORT_A_SEL) < NUM_REGS) a_val = regs_q[bus.I_READ_PORT_A_SEL];
      if (int'(bus.I_READ_PORT_B_SEL) < NUM_REGS) b_reg = regs_q[bus.I_READ_PORT_B_SEL];
      if (wb_we_q && (wb_sel_q == bus.I_READ_PORT_A_SEL)) a_val = wr_q;
      if (wb_we_q && (wb_sel_q == bus.I_READ_PORT_B_SEL)) b_reg = wr_q;
      b_val = bus.I_IMM_SEL ? bus.I_IMMEDIATE : b_reg;
   end

   always_comb begin
      op      = op_e'(bus.I_OPCODE);
      amt     = b_val[SHW-1:0];
      sum     = {1'b0, a_val} + {1'b0, b_val}
                + {{DATA_WIDTH{1'b0}}, (op == OP_ADDC) & flags_q[4]};
      diff    = {1'b0, a_val} - {1'b0, b_val};
      wr_d    = '0;
      flags_d = flags_q;
      writes  = 1'b1;
      ovf     = 1'b0;
      case (op)
         OP_ADD, OP_ADDC: begin
            wr_d       = sum[DATA_WIDTH-1:0];
            ovf        = (a_val[DATA_WIDTH-1] == b_val[DATA_WIDTH-1]) &&
                         (wr_d[DATA_WIDTH-1] != a_val[DATA_WIDTH-1]);
            flags_d[4] = sum[DATA_WIDTH];
            flags_d[2] = ovf;
            flags_d[1] = (wr_d == '0);
            flags_d[0] = wr_d[DATA_WIDTH-1];
         end
         OP_SUB, OP_CMP: begin
            wr_d       = diff[DATA_WIDTH-1:0];
            ovf        = (a_val[DATA_WIDTH-1] != b_val[DATA_WIDTH-1]) &&
                         (wr_d[DATA_WIDTH-1] != a_val[DATA_WIDTH-1]);
            flags_d[4] = diff[DATA_WIDTH];
            flags_d[3] = diff[DATA_WIDTH];
            flags_d[2] = ovf;
            flags_d[1] = (a_val == b_val);
            flags_d[0] = wr_d[DATA_WIDTH-1] ^ ovf;
            writes     = (op == OP_SUB);
         end
         OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_RSH, OP_NOT: begin
            case (op)
               OP_AND:  wr_d = a_val & b_val;
               OP_OR:   wr_d = a_val | b_val;
               OP_XOR:  wr_d = a_val ^ b_val;
               OP_MOV:  wr_d = b_val;
               OP_LSH:  wr_d = (int'(amt) >= DATA_WIDTH) ? '0 : (a_val << amt);
               OP_RSH:  wr_d = (int'(amt) >= DATA_WIDTH) ? '0 : (a_val >> amt);
               default: wr_d = ~a_val;
            endcase
            flags_d[1] = (wr_d == '0);
            flags_d[0] = wr_d[DATA_WIDTH-1];
         end
         default: writes = 1'b0;
      endcase
      // Dropping out-of-range writes here keeps them out of the bypass compare too.
      wb_we_d = bus.I_WRITE_EN && writes && (int'(bus.I_WRITE_SEL) < NUM_REGS);
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_q     <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
         wb_we_q  <= 1'b0;
         wb_sel_q <= '0;
      end else if (bus.I_ENABLE) begin
         if (wb_we_q) regs_q[wb_sel_q] <= wr_q;
         if (bus.I_VALID) begin
            wr_q     <= wr_d;
            flags_q  <= flags_d;
            valid_q  <= 1'b1;
            wb_we_q  <= wb_we_d;
            wb_sel_q <= bus.I_WRITE_SEL;
         end else begin
            valid_q  <= 1'b0;
            wb_we_q  <= 1'b0;
         end
      end
   end

   assign bus.O_WRITE_PORT   = wr_q;
   assign bus.O_FLAGS        = flags_q;
   assign bus.O_RESULT_VALID = valid_q;
endmodule

// File: tb/tb_cr16_datapath_pipe.sv
// Scoreboard bench for cr16_datapath_pipe: a sequential instruction-level model predicts
// each result; a monitor compares every cycle against the queued expectations.
module tb_cr16_datapath_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cr16_datapath_pipe_if #(.DATA_WIDTH(16), .SEL_WIDTH(4)) bus ();
   cr16_datapath_pipe #(.DATA_WIDTH(16), .NUM_REGS(16), .SEL_WIDTH(4)) dut (
      .I_CLK(clk), .I_NRESET(rst_n), .bus(bus)
   );

   typedef struct { logic [15:0] wp; logic [4:0] fl; } exp_t;
   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned mreg[16];
   logic [4:0]  mfl = '0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sgn(input int unsigned v);
      return (v >= 32768) ? int'(v) - 65536 : int'(v);
   endfunction

   // Architectural semantics: one op at a time, registers updated immediately.
   task automatic model(input int op, input int unsigned a, input int unsigned b,
                        output int unsigned res, output bit wr);
      bit c, l, f, z, n;
      int unsigned s, cin;
      int ss;
      {c, l, f, z, n} = mfl;
      wr = 1'b1;
      res = 0;
      case (op)
         0, 9: begin
            cin = (op == 9) ? int'(c) : 0;
            s   = a + b + cin;
            res = s % 65536;
            ss  = sgn(a) + sgn(b) + int'(cin);
            c = (s > 65535); f = (ss > 32767) || (ss < -32768);
            z = (res == 0);  n = (res >= 32768);
         end
         1, 6: begin
            res = (a + 65536 - b) % 65536;
            ss  = sgn(a) - sgn(b);
            c = (a < b); l = (a < b); f = (ss > 32767) || (ss < -32768);
            z = (a == b); n = (sgn(a) < sgn(b));
            wr = (op == 1);
         end
         2, 3, 4, 5, 7, 8, 10: begin
            case (op)
               2: res = a & b;
               3: res = a | b;
               4: res = a ^ b;
               5: res = b;
               7: res = (a << (b % 16)) % 65536;
               8: res = a >> (b % 16);
               default: res = (~a) & 32'hFFFF;
            endcase
            z = (res == 0); n = (res >= 32768);
         end
         default: wr = 1'b0;
      endcase
      if (op <= 10) mfl = {c, l, f, z, n};
   endtask

   task automatic issue(input int op, input int a, input int b, input int w,
                        input bit we, input int unsigned imm, input bit isel);
      int unsigned res, bv;
      bit wr;
      exp_t e;
      bus.I_ENABLE = 1'b1; bus.I_VALID = 1'b1; bus.I_OPCODE = 4'(op);
      bus.I_READ_PORT_A_SEL = 4'(a); bus.I_READ_PORT_B_SEL = 4'(b);
      bus.I_WRITE_SEL = 4'(w); bus.I_WRITE_EN = we;
      bus.I_IMMEDIATE = 16'(imm); bus.I_IMM_SEL = isel;
      bv = isel ? (imm & 32'hFFFF) : mreg[b];
      model(op, mreg[a], bv, res, wr);
      if (wr && we) mreg[w] = res;
      e.wp = 16'(res); e.fl = mfl;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic bubble();
      bus.I_ENABLE = 1'b1; bus.I_VALID = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         bus.I_ENABLE = 1'b0; bus.I_VALID = 1'($urandom);
         bus.I_OPCODE = 4'($urandom); bus.I_WRITE_EN = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic probe(input int r);
      issue(5, 0, r, 0, 1'b0, 0, 1'b0);
   endtask

   // Monitor: fresh result after an enabled issue edge, otherwise the outputs must hold.
   initial begin
      bit en, fresh;
      exp_t e;
      logic [15:0] lwp = '0;
      logic [4:0]  lfl = '0;
      bit          lv  = 1'b0;
      forever begin
         @(posedge clk);
         en    = bus.I_ENABLE && rst_n;
         fresh = en && bus.I_VALID;
         @(negedge clk);
         if (!rst_n) begin
            lwp = '0; lfl = '0; lv = 1'b0;
         end else if (fresh) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               lwp = e.wp; lfl = e.fl; lv = 1'b1;
            end
         end else if (en) begin
            lv = 1'b0;
         end
         check("write_port", bus.O_WRITE_PORT, lwp);
         check("flags", bus.O_FLAGS, lfl);
         check("result_valid", bus.O_RESULT_VALID, lv);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mreg[i] = 0;
      bus.I_ENABLE = 1'b0; bus.I_VALID = 1'b0; bus.I_OPCODE = '0;
      bus.I_READ_PORT_A_SEL = '0; bus.I_READ_PORT_B_SEL = '0; bus.I_WRITE_SEL = '0;
      bus.I_WRITE_EN = 1'b0; bus.I_IMMEDIATE = '0; bus.I_IMM_SEL = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bubble();

      // Fibonacci chain, fully dependent back-to-back
      issue(5, 0, 0, 0, 1'b1, 1, 1'b1);
      issue(5, 0, 0, 1, 1'b1, 1, 1'b1);
      for (int n = 2; n < 16; n++) issue(0, n - 1, n - 2, n, 1'b1, 0, 1'b0);
      bubble();
      check("fib_r15_model", mreg[15], 987);
      probe(15);

      // Signed overflow and carry
      issue(5, 0, 0, 2, 1'b1, 16'h7FFF, 1'b1);
      issue(0, 2, 0, 3, 1'b1, 1, 1'b1);
      issue(5, 0, 0, 2, 1'b1, 16'hFFFF, 1'b1);
      issue(0, 2, 0, 3, 1'b1, 1, 1'b1);

      // 32-bit add via ADD + ADDC
      issue(5, 0, 0, 5, 1'b1, 16'hFFFF, 1'b1);
      issue(5, 0, 0, 7, 1'b1, 16'h0001, 1'b1);
      issue(0, 5, 0, 8, 1'b1, 1, 1'b1);
      issue(9, 7, 0, 9, 1'b1, 0, 1'b1);
      probe(8); probe(9);

      // CMP never writes
      issue(5, 0, 0, 10, 1'b1, 3, 1'b1);
      issue(5, 0, 0, 11, 1'b1, 5, 1'b1);
      issue(6, 10, 11, 10, 1'b1, 0, 1'b0);
      issue(6, 11, 11, 11, 1'b1, 0, 1'b0);
      probe(10); probe(11);

      // Stall between EX and WB, then consume via bypass
      issue(0, 0, 1, 12, 1'b1, 0, 1'b0);
      stall(3);
      issue(0, 12, 0, 13, 1'b1, 16'h0100, 1'b1);
      probe(12); probe(13);

      // Shifts including large amounts, bubbles in between
      issue(7, 15, 0, 14, 1'b1, 16'h000F, 1'b1);
      bubble();
      issue(8, 14, 0, 14, 1'b1, 16'h0004, 1'b1);
      issue(10, 14, 0, 6, 1'b1, 0, 1'b1);
      issue(12, 14, 0, 6, 1'b1, 0, 1'b1);
      probe(6);

      for (int k = 0; k < 250; k++) begin
         case ($urandom_range(0, 9))
            0: stall(int'($urandom_range(1, 2)));
            1: bubble();
            default: issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           1'($urandom), $urandom_range(0, 65535), 1'($urandom));
         endcase
      end
      for (int r = 0; r < 16; r++) probe(r);

      // Async reset between EX and WB of a write to r4
      issue(5, 0, 0, 4, 1'b1, 16'h0055, 1'b1);
      #5 rst_n = 1'b0;
      #1;
      check("rst_async_wp", bus.O_WRITE_PORT, 0);
      check("rst_async_valid", bus.O_RESULT_VALID, 0);
      check("rst_async_flags", bus.O_FLAGS, 0);
      bus.I_VALID = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      for (int i = 0; i < 16; i++) mreg[i] = 0;
      mfl = '0;
      bubble();
      probe(4);
      bubble();
      bubble();
      check("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
